uart_rx_ovs: RTL and testbench

Parametrised second-generation UART receiver for the multi-clock system's UART clock domain. It supports runtime-selectable data length, optional parity, and one or two stop bits. It takes a 3-sample majority vote per bit and delivers each frame through a valid/ready output register with overrun detection. Optional break detection can be compiled in. It sits between the RX pad synchroniser path and the RX-side handshake/CDC logic feeding the system controller.

---
 rtl/uart_rx_pkg.sv | 17 +
 rtl/uart_rx_ovs_sampler.sv | 31 +++
 rtl/uart_rx_ovs.sv | 205 ++++++++++++++++++++
 tb/tb_uart_rx_ovs.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared FSM encoding and constants for the oversampling UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } rx_state_t;

    localparam logic PAR_EVEN     = 1'b0;
    localparam logic PAR_ODD      = 1'b1;
    localparam int   MIN_PRESCALE = 4;

endpackage

// File: rtl/uart_rx_ovs_sampler.sv
// rx_maj_sampler: 2-of-3 vote around the centre of each oversampled bit.
module rx_maj_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] cnt,
    input  logic [PRESCALE_W-1:0] half,
    input  logic                  rx,
    output logic                  vote,
    output logic                  bit_done
);

    logic s_a;
    logic s_b;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s_a <= 1'b0;
            s_b <= 1'b0;
        end else begin
            if (cnt == half - 1'b1) s_a <= rx;
            if (cnt == half)        s_b <= rx;
        end
    end

    // third sample is the live line at h+1, so the vote is ready that cycle
    assign vote     = (s_a & s_b) | (s_a & rx) | (s_b & rx);
    assign bit_done = (cnt == half + 1'b1);

endmodule

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receiver with valid/ready output and overrun flag.
// Break detection is compiled in with UART_RX_BREAK_DET_EN.
module uart_rx_ovs #(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic [3:0]            DATA_LEN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic [DATA_W-1:0]     P_DATA,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  ovr_err,
    output logic                  brk_det
);
    import uart_rx_pkg::*;

    logic                  rx_s1, rx_s2, rx_d;
    logic                  start_det;
    rx_state_t             state_q, state_d;
    logic [PRESCALE_W-1:0] cnt_q, pre_q, half;
    logic [3:0]            len_q, bit_idx_q;
    logic                  par_en_q, par_typ_q, stop2_q;
    logic [DATA_W-1:0]     data_q;
    logic                  par_bit_q, stp_acc_q;
    logic                  vote, bit_done, bit_end, last_bit;
    logic                  frame_done, frame_par, frame_stp;
    logic                  brk_hit, brk_hold;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= RX_IN;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign half      = pre_q >> 1;
    assign bit_end   = (cnt_q == pre_q - 1'b1);
    assign last_bit  = (bit_idx_q == len_q - 4'd1);
    assign start_det = (state_q == ST_IDLE) & rx_d & ~rx_s2 & ~brk_hold;

    rx_maj_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
        .clk      (CLK),
        .rst      (RST),
        .cnt      (cnt_q),
        .half     (half),
        .rx       (rx_s2),
        .vote     (vote),
        .bit_done (bit_done)
    );

    always_ff @(posedge CLK) begin
        if (!RST) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start_det) state_d = ST_START;
            ST_START: begin
                if (bit_done && vote) state_d = ST_IDLE;
                else if (bit_end)     state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && last_bit)
                    state_d = par_en_q ? ST_PARITY : ST_STOP1;
            end
            ST_PARITY: if (bit_end) state_d = ST_STOP1;
            ST_STOP1: begin
                if (bit_done && (brk_hit || !stop2_q)) state_d = ST_IDLE;
                else if (bit_end)                      state_d = ST_STOP2;
            end
            ST_STOP2:  if (bit_done) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // last stop bit completes at its vote, not at the end of the bit
    always_comb begin
        frame_done = 1'b0;
        unique case (state_q)
            ST_STOP1: frame_done = bit_done & ~stop2_q & ~brk_hit;
            ST_STOP2: frame_done = bit_done;
            default:  frame_done = 1'b0;
        endcase
    end

    assign frame_stp = stp_acc_q | ~vote;
    assign frame_par = par_en_q & (par_bit_q ^ (^data_q) ^ (par_typ_q == PAR_ODD));

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q     <= '0;
            pre_q     <= '0;
            len_q     <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
            stop2_q   <= 1'b0;
            data_q    <= '0;
            bit_idx_q <= '0;
            par_bit_q <= 1'b0;
            stp_acc_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE) begin
                cnt_q <= start_det ? PRESCALE_W'(1) : '0;
                if (start_det) begin
                    pre_q     <= Prescale;
                    len_q     <= DATA_LEN;
                    par_en_q  <= PAR_EN;
                    par_typ_q <= PAR_TYP;
                    stop2_q   <= STOP2;
                    data_q    <= '0;
                    bit_idx_q <= '0;
                    par_bit_q <= 1'b0;
                    stp_acc_q <= 1'b0;
                end
            end else begin
                cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
            end
            if (state_q == ST_DATA && bit_done) begin
                for (int i = 0; i < DATA_W; i++)
                    if (bit_idx_q == 4'(i)) data_q[i] <= vote;
            end
            if (state_q == ST_DATA && bit_end) bit_idx_q <= bit_idx_q + 4'd1;
            if (state_q == ST_PARITY && bit_done) par_bit_q <= vote;
            if (state_q == ST_STOP1 && bit_done) stp_acc_q <= ~vote;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            ovr_err    <= 1'b0;
        end else begin
            ovr_err <= 1'b0;
            if (frame_done) begin
                if (!data_valid || data_ready) begin
                    P_DATA     <= data_q;
                    par_err    <= frame_par;
                    stp_err    <= frame_stp;
                    data_valid <= 1'b1;
                end else begin
                    ovr_err <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    logic                  all_zero_q;
    logic                  brk_hold_q;
    logic [PRESCALE_W-1:0] hold_cnt_q;

    assign brk_hit  = (state_q == ST_STOP1) & bit_done & ~vote & all_zero_q;
    assign brk_hold = brk_hold_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            all_zero_q <= 1'b0;
            brk_hold_q <= 1'b0;
            hold_cnt_q <= '0;
            brk_det    <= 1'b0;
        end else begin
            brk_det <= brk_hit;
            if (start_det)
                all_zero_q <= 1'b1;
            else if (bit_done && vote &&
                     (state_q inside {ST_START, ST_DATA, ST_PARITY}))
                all_zero_q <= 1'b0;
            // re-arm only after a full bit time of idle-high line
            if (brk_hit) begin
                brk_hold_q <= 1'b1;
                hold_cnt_q <= '0;
            end else if (brk_hold_q) begin
                if (!rx_s2)                          hold_cnt_q <= '0;
                else if (hold_cnt_q == pre_q - 1'b1) brk_hold_q <= 1'b0;
                else                                 hold_cnt_q <= hold_cnt_q + 1'b1;
            end
        end
    end
`else
    assign brk_hit  = 1'b0;
    assign brk_hold = 1'b0;
    assign brk_det  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb_uart_rx_ovs: table-driven frames checked through a scoreboard queue,
// plus hand sequences for glitch, overrun, break and mid-frame reset.
module tb_uart_rx_ovs;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic [3:0] DATA_LEN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       STOP2;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       data_ready;
    logic       par_err;
    logic       stp_err;
    logic       ovr_err;
    logic       brk_det;

    uart_rx_ovs #(.DATA_W(8), .PRESCALE_W(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .DATA_LEN   (DATA_LEN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .ovr_err    (ovr_err),
        .brk_det    (brk_det)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] d;
        int         len;
        logic       par_en;
        logic       par_typ;
        logic       stop2;
        int         pre;
        logic       flip;
        logic       bad1;
        logic       bad2;
        int         noise_bit;
        logic [7:0] ed;
        logic       ep;
        logic       es;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
    } exp_t;

    localparam int NV = 11;
    vec_t vt [NV];
    exp_t sb [$];

    int checks  = 0;
    int errors  = 0;
    int ovr_cnt = 0;
    int brk_cnt = 0;
    int hs_cnt  = 0;

    always @(negedge CLK) begin
        exp_t e;
        if (RST) begin
            if (ovr_err) ovr_cnt++;
            if (brk_det) brk_cnt++;
            if (data_valid && data_ready) begin
                hs_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got d=%0h p=%0b s=%0b required none",
                             P_DATA, par_err, stp_err);
                end else begin
                    e = sb.pop_front();
                    if ({P_DATA, par_err, stp_err} !== {e.d, e.p, e.s}) begin
                        errors++;
                        $display("FAIL sb_frame got d=%0h p=%0b s=%0b required d=%0h p=%0b s=%0b",
                                 P_DATA, par_err, stp_err, e.d, e.p, e.s);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int pre, input int noise_at);
        for (int c = 0; c < pre; c++) begin
            RX_IN = (c == noise_at) ? ~b : b;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send(input vec_t v);
        logic par;
        Prescale = 6'(v.pre);
        DATA_LEN = 4'(v.len);
        PAR_EN   = v.par_en;
        PAR_TYP  = v.par_typ;
        STOP2    = v.stop2;
        par      = v.par_typ ^ v.flip;
        drive_bit(1'b0, v.pre, -1);
        for (int i = 0; i < v.len; i++) begin
            par ^= v.d[i];
            drive_bit(v.d[i], v.pre, (i == v.noise_bit) ? v.pre / 2 : -1);
        end
        if (v.par_en) drive_bit(par, v.pre, -1);
        drive_bit(~v.bad1, v.pre, -1);
        if (v.stop2) drive_bit(~v.bad2, v.pre, -1);
        RX_IN = 1'b1;
    endtask

    function automatic vec_t mk(input logic [7:0] d);
        vec_t v;
        v = '{d, 8, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0, 1'b0, -1, d, 1'b0, 1'b0};
        return v;
    endfunction

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending %0d required 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int n1;
        RST = 1'b0; RX_IN = 1'b1; data_ready = 1'b1;
        Prescale = 6'd8; DATA_LEN = 4'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;

        //        d      len pe    pt    s2    pre fl    b1    b2    nb  ed     ep    es
        vt[0]  = '{8'hA5, 8, 1'b1, 1'b0, 1'b0, 8, 1'b0, 1'b0, 1'b0, -1, 8'hA5, 1'b0, 1'b0};
        vt[1]  = '{8'hA5, 8, 1'b1, 1'b0, 1'b0, 8, 1'b1, 1'b0, 1'b0, -1, 8'hA5, 1'b1, 1'b0};
        vt[2]  = '{8'hD5, 7, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0, 1'b0, -1, 8'h55, 1'b0, 1'b0};
        vt[3]  = '{8'h3C, 8, 1'b1, 1'b1, 1'b0, 16, 1'b0, 1'b0, 1'b0, -1, 8'h3C, 1'b0, 1'b0};
        vt[4]  = '{8'h81, 8, 1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b0, 1'b1, -1, 8'h81, 1'b0, 1'b1};
        vt[5]  = '{8'h7E, 8, 1'b0, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0, -1, 8'h7E, 1'b0, 1'b0};
        vt[6]  = '{8'h1F, 5, 1'b1, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0, -1, 8'h1F, 1'b0, 1'b0};
        vt[7]  = '{8'h2A, 6, 1'b1, 1'b1, 1'b0, 8, 1'b1, 1'b0, 1'b0, -1, 8'h2A, 1'b1, 1'b0};
        vt[8]  = '{8'hF0, 8, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b1, 1'b0, -1, 8'hF0, 1'b0, 1'b1};
        vt[9]  = '{8'hA5, 8, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0, 1'b0, 2, 8'hA5, 1'b0, 1'b0};
        vt[10] = '{8'h5A, 8, 1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b0, 0, 8'h5A, 1'b0, 1'b0};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_p_data", P_DATA, 0);
        chk("rst_dv", data_valid, 0);
        chk("rst_par", par_err, 0);
        chk("rst_stp", stp_err, 0);
        chk("rst_ovr", ovr_err, 0);
        chk("rst_brk", brk_det, 0);
        @(posedge CLK); #1;
        RST = 1'b1;
        repeat (4) @(posedge CLK); #1;

        for (int i = 0; i < NV; i++) begin
            sb.push_back('{vt[i].ed, vt[i].ep, vt[i].es});
            send(vt[i]);
            drive_bit(1'b1, vt[i].pre, -1);
            wait_drain($sformatf("vec%0d", i));
            @(negedge CLK);
            chk($sformatf("vec%0d_dv_drop", i), data_valid, 0);
            @(posedge CLK); #1;
        end

        Prescale = 6'd16;
        n0 = hs_cnt;
        RX_IN = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        RX_IN = 1'b1;
        repeat (60) begin @(posedge CLK); #1; end
        chk("glitch_no_frame", hs_cnt - n0, 0);
        chk("glitch_dv", data_valid, 0);

        data_ready = 1'b0;
        n0 = ovr_cnt;
        sb.push_back('{8'h11, 1'b0, 1'b0});
        send(mk(8'h11));
        send(mk(8'h22));
        drive_bit(1'b1, 8, -1);
        repeat (4) @(negedge CLK);
        chk("ovr_pulse_count", ovr_cnt - n0, 1);
        chk("ovr_hold_data", P_DATA, 8'h11);
        chk("ovr_hold_dv", data_valid, 1);
        data_ready = 1'b1;
        wait_drain("ovr_drain");
        @(posedge CLK); #1;

        n0 = ovr_cnt;
        sb.push_back('{8'h11, 1'b0, 1'b0});
        sb.push_back('{8'h22, 1'b0, 1'b0});
        send(mk(8'h11));
        send(mk(8'h22));
        drive_bit(1'b1, 8, -1);
        wait_drain("b2b");
        chk("b2b_no_ovr", ovr_cnt - n0, 0);
        @(posedge CLK); #1;

        n0 = brk_cnt;
        n1 = hs_cnt;
        Prescale = 6'd8; DATA_LEN = 4'd8; PAR_EN = 1'b0; STOP2 = 1'b0;
`ifndef UART_RX_BREAK_DET_EN
        sb.push_back('{8'h00, 1'b0, 1'b1});
`endif
        RX_IN = 1'b0;
        repeat (12 * 8) begin @(posedge CLK); #1; end
        RX_IN = 1'b1;
        repeat (3 * 8) begin @(posedge CLK); #1; end
`ifdef UART_RX_BREAK_DET_EN
        chk("brk_pulse_count", brk_cnt - n0, 1);
        chk("brk_no_data", hs_cnt - n1, 0);
        chk("brk_dv", data_valid, 0);
`else
        wait_drain("brk_as_frame");
        chk("brk_tied_low", brk_cnt - n0, 0);
`endif
        sb.push_back('{8'h66, 1'b0, 1'b0});
        send(mk(8'h66));
        drive_bit(1'b1, 8, -1);
        wait_drain("post_brk");

        Prescale = 6'd8; DATA_LEN = 4'd8; PAR_EN = 1'b0; STOP2 = 1'b0;
        drive_bit(1'b0, 8, -1);
        drive_bit(1'b1, 8, -1);
        drive_bit(1'b0, 8, -1);
        drive_bit(1'b0, 8, -1);
        RX_IN = 1'b1;
        RST = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk("rstmid_p_data", P_DATA, 0);
        chk("rstmid_dv", data_valid, 0);
        chk("rstmid_par", par_err, 0);
        chk("rstmid_stp", stp_err, 0);
        chk("rstmid_ovr", ovr_err, 0);
        chk("rstmid_brk", brk_det, 0);
        @(posedge CLK); #1;
        RST = 1'b1;
        repeat (10) begin @(posedge CLK); #1; end
        sb.push_back('{8'h3C, 1'b0, 1'b0});
        send(mk(8'h3C));
        drive_bit(1'b1, 8, -1);
        wait_drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
